// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation
// encodings as seen on the op port and the iteration FSM states.
package muldiv_pkg;

   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

endpackage

// File: rtl/twos_negate.sv
// Conditional two's-complement negate. Used both to take operand
// magnitudes before iterating and to restore result signs afterwards.
module twos_negate #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] value,
   input  logic             negate,
   output logic [WIDTH-1:0] result
);

   assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO pair.
// Operands are reduced to magnitudes at launch, one radix-2 step is done
// per RUN cycle (shift-add or restoring shift-subtract), and the signs are
// restored in FIX as the result is committed to HI/LO.
module hilo_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [2*WIDTH-1:0]     acc_q, acc_step;
   logic [WIDTH-1:0]       opnd_q;
   logic                   is_div_q, dbz_q, neg_lo_q, neg_hi_q;
   logic [WIDTH-1:0]       hi_q, lo_q;
   logic                   done_q, dbz_out_q;

   logic                   is_div_op, is_signed_op, sign_a, sign_b, dbz_now;
   logic [WIDTH-1:0]       abs_a, abs_b;
   logic [WIDTH:0]         mul_sum, rem_shift;
   logic [WIDTH-1:0]       rem_diff;
   logic [2*WIDTH-1:0]     prod_fixed;
   logic [WIDTH-1:0]       quot_fixed, rem_fixed;
   logic                   last_step;

   assign is_div_op    = (op == MD_DIV) || (op == MD_DIVU);
   assign is_signed_op = (op == MD_MULT) || (op == MD_DIV);
   assign sign_a       = is_signed_op & a[WIDTH-1];
   assign sign_b       = is_signed_op & b[WIDTH-1];
   assign dbz_now      = is_div_op && (b == '0);
   assign last_step    = (cnt_q == CNT_W'(WIDTH-1));

   twos_negate #(.WIDTH(WIDTH)) u_abs_a (.value(a), .negate(sign_a), .result(abs_a));
   twos_negate #(.WIDTH(WIDTH)) u_abs_b (.value(b), .negate(sign_b), .result(abs_b));

   twos_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
      .value(acc_q), .negate(neg_lo_q), .result(prod_fixed));
   twos_negate #(.WIDTH(WIDTH)) u_fix_quot (
      .value(acc_q[WIDTH-1:0]), .negate(neg_lo_q), .result(quot_fixed));
   twos_negate #(.WIDTH(WIDTH)) u_fix_rem (
      .value(acc_q[2*WIDTH-1:WIDTH]), .negate(neg_hi_q), .result(rem_fixed));

   // One radix-2 step: multiply adds the multiplicand when the low bit is
   // set and shifts right; divide shifts the next dividend bit into the
   // remainder and subtracts the divisor when it fits.
   always_comb begin
      acc_step  = acc_q;
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      rem_diff  = rem_shift[WIDTH-1:0] - opnd_q;
      if (is_div_q) begin
         if (rem_shift >= {1'b0, opnd_q})
            acc_step = {rem_diff, acc_q[WIDTH-2:0], 1'b1};
         else
            acc_step = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
         acc_step = {mul_sum, acc_q[WIDTH-1:1]};
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Next state: divide-by-zero skips straight to FIX.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = dbz_now ? ST_FIX : ST_RUN;
         ST_RUN:  if (last_step) state_d = ST_FIX;
         ST_FIX:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath: operand capture, iteration, commit and mthi/mtlo writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         is_div_q  <= 1'b0;
         dbz_q     <= 1'b0;
         neg_lo_q  <= 1'b0;
         neg_hi_q  <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         dbz_out_q <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         dbz_out_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  cnt_q    <= '0;
                  acc_q    <= is_div_op ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
                  opnd_q   <= is_div_op ? abs_b : abs_a;
                  is_div_q <= is_div_op;
                  dbz_q    <= dbz_now;
                  neg_lo_q <= sign_a ^ sign_b;
                  neg_hi_q <= sign_a;
               end else begin
                  if (hi_we) hi_q <= wdata;
                  if (lo_we) lo_q <= wdata;
               end
            end
            ST_RUN: begin
               acc_q <= acc_step;
               cnt_q <= cnt_q + CNT_W'(1);
            end
            ST_FIX: begin
               cnt_q     <= '0;
               done_q    <= 1'b1;
               dbz_out_q <= dbz_q;
               if (!dbz_q) begin
                  if (is_div_q) begin
                     lo_q <= quot_fixed;
                     hi_q <= rem_fixed;
                  end else begin
                     {hi_q, lo_q} <= prod_fixed;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign div_by_zero = dbz_out_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed testbench for hilo_muldiv_unit: multiply/divide results,
// latency, divide-by-zero, dropped writes/starts while busy, reset mid-op.
module tb_hilo_muldiv_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        hi_we, lo_we;
   logic [31:0] wdata;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   int errors = 0;
   int checks = 0;

   hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Launch one op from IDLE and wait (bounded) for done; reports edges from
   // E0 to done and how many in-flight samples saw busy low.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int idle_cnt);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1;
      idle_cnt = 0;
      if (!busy) idle_cnt++;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = k;
            break;
         end
         if (!busy) idle_cnt++;
      end
   endtask

   task automatic write_hilo(input logic [31:0] hv, input logic [31:0] lv);
      hi_we = 1'b1; lo_we = 1'b0; wdata = hv;
      @(posedge clk); #1;
      hi_we = 1'b0; lo_we = 1'b1; wdata = lv;
      @(posedge clk); #1;
      lo_we = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%0b want=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%0b want=0", done); end
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbz got=%0b want=0", div_by_zero); end
      checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi got=%h want=00000000", hi); end
      checks++; if (lo !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo got=%h want=00000000", lo); end
   endtask

   task automatic test_multu_basic();
      int lat, idle_cnt;
      run_op(2'b01, 32'd123, 32'd456, lat, idle_cnt);
      checks++; if (lat != 33) begin errors++; $display("[TB] FAIL multu_latency got=%0d want=33", lat); end
      checks++; if (idle_cnt != 0) begin errors++; $display("[TB] FAIL multu_busy_gaps got=%0d want=0", idle_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL multu_busy_at_done got=%0b want=0", busy); end
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL multu_dbz got=%0b want=0", div_by_zero); end
      checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL multu_hi got=%h want=00000000", hi); end
      checks++; if (lo !== 32'h0000DB18) begin errors++; $display("[TB] FAIL multu_lo got=%h want=0000db18", lo); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL multu_done_pulse got=%0b want=0", done); end
   endtask

   task automatic test_mult_signed();
      int lat, idle_cnt;
      run_op(2'b00, 32'hFFFFFFFF, 32'd2, lat, idle_cnt);
      checks++; if (lat != 33) begin errors++; $display("[TB] FAIL mult_latency got=%0d want=33", lat); end
      checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mult_hi got=%h want=ffffffff", hi); end
      checks++; if (lo !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL mult_lo got=%h want=fffffffe", lo); end
      run_op(2'b01, 32'hFFFFFFFF, 32'd2, lat, idle_cnt);
      checks++; if (hi !== 32'h00000001) begin errors++; $display("[TB] FAIL multu2_hi got=%h want=00000001", hi); end
      checks++; if (lo !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL multu2_lo got=%h want=fffffffe", lo); end
      run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, idle_cnt);
      checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL multu_max_hi got=%h want=fffffffe", hi); end
      checks++; if (lo !== 32'h00000001) begin errors++; $display("[TB] FAIL multu_max_lo got=%h want=00000001", lo); end
   endtask

   task automatic test_divide();
      int lat, idle_cnt;
      run_op(2'b11, 32'd100, 32'd7, lat, idle_cnt);
      checks++; if (lat != 33) begin errors++; $display("[TB] FAIL divu_latency got=%0d want=33", lat); end
      checks++; if (lo !== 32'd14) begin errors++; $display("[TB] FAIL divu_lo got=%h want=0000000e", lo); end
      checks++; if (hi !== 32'd2) begin errors++; $display("[TB] FAIL divu_hi got=%h want=00000002", hi); end
      run_op(2'b10, 32'hFFFFFFF9, 32'd2, lat, idle_cnt);
      checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_neg_lo got=%h want=fffffffd", lo); end
      checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL div_neg_hi got=%h want=ffffffff", hi); end
      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, idle_cnt);
      checks++; if (lo !== 32'h80000000) begin errors++; $display("[TB] FAIL div_ovf_lo got=%h want=80000000", lo); end
      checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL div_ovf_hi got=%h want=00000000", hi); end
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL div_ovf_dbz got=%0b want=0", div_by_zero); end
   endtask

   task automatic test_div_by_zero();
      int lat, idle_cnt;
      write_hilo(32'hA, 32'hB);
      checks++; if (hi !== 32'hA) begin errors++; $display("[TB] FAIL mthi got=%h want=0000000a", hi); end
      checks++; if (lo !== 32'hB) begin errors++; $display("[TB] FAIL mtlo got=%h want=0000000b", lo); end
      run_op(2'b10, 32'd5, 32'd0, lat, idle_cnt);
      checks++; if (lat != 1) begin errors++; $display("[TB] FAIL dbz_latency got=%0d want=1", lat); end
      checks++; if (div_by_zero !== 1'b1) begin errors++; $display("[TB] FAIL dbz_flag got=%0b want=1", div_by_zero); end
      checks++; if (hi !== 32'hA) begin errors++; $display("[TB] FAIL dbz_hi got=%h want=0000000a", hi); end
      checks++; if (lo !== 32'hB) begin errors++; $display("[TB] FAIL dbz_lo got=%h want=0000000b", lo); end
      @(posedge clk); #1;
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL dbz_flag_clear got=%0b want=0", div_by_zero); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL dbz_done_clear got=%0b want=0", done); end
   endtask

   task automatic test_busy_ignore();
      int lat;
      write_hilo(32'h0, 32'h55);
      // start coincides with an mtlo: start wins, the write is dropped
      op = 2'b01; a = 32'd3; b = 32'd5; start = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
      @(posedge clk); #1;
      start = 1'b0; lo_we = 1'b0;
      checks++; if (lo !== 32'h55) begin errors++; $display("[TB] FAIL start_vs_mtlo got=%h want=00000055", lo); end
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         if (k == 3) begin
            op = 2'b01; a = 32'd7; b = 32'd7; start = 1'b1; lo_we = 1'b1; wdata = 32'h1234;
         end else begin
            start = 1'b0; lo_we = 1'b0;
         end
         @(posedge clk); #1;
         if (k == 5) begin
            checks++; if (lo !== 32'h55) begin errors++; $display("[TB] FAIL run_lo_hold got=%h want=00000055", lo); end
         end
         if (done) begin
            lat = k;
            break;
         end
      end
      start = 1'b0; lo_we = 1'b0;
      checks++; if (lat != 33) begin errors++; $display("[TB] FAIL ignore_latency got=%0d want=33", lat); end
      checks++; if (lo !== 32'd15) begin errors++; $display("[TB] FAIL ignore_lo got=%h want=0000000f", lo); end
      checks++; if (hi !== 32'd0) begin errors++; $display("[TB] FAIL ignore_hi got=%h want=00000000", hi); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL no_queue_busy got=%0b want=0", busy); end
   endtask

   task automatic test_reset_mid_op();
      int lat, idle_cnt;
      write_hilo(32'h1111, 32'h2222);
      op = 2'b01; a = 32'd9; b = 32'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_busy got=%0b want=1", busy); end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got=%0b want=0", busy); end
      checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL abort_hi got=%h want=00000000", hi); end
      checks++; if (lo !== 32'h0) begin errors++; $display("[TB] FAIL abort_lo got=%h want=00000000", lo); end
      run_op(2'b01, 32'h00010000, 32'h00010000, lat, idle_cnt);
      checks++; if (lat != 33) begin errors++; $display("[TB] FAIL fresh_latency got=%0d want=33", lat); end
      checks++; if (hi !== 32'h1) begin errors++; $display("[TB] FAIL fresh_hi got=%h want=00000001", hi); end
      checks++; if (lo !== 32'h0) begin errors++; $display("[TB] FAIL fresh_lo got=%h want=00000000", lo); end
   endtask

   // Test sequence.
   initial begin
      reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
      test_reset();
      test_multu_basic();
      test_mult_signed();
      test_divide();
      test_div_by_zero();
      test_busy_ignore();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
